cp0_nested_irq: RTL and testbench
=================================

Name: cp0_nested_irq

Overview:
- Parametrised successor coprocessor-0 for the single-cycle MIPS CPU.
- Adds the following over the existing CP0:
  - level-sensitive external interrupt lines;
  - a Count/Compare timer interrupt;
  - a hardware Status/EPC stack, so nested exceptions return correctly.
- Sits beside the register file: the datapath reads through mfc0, writes through mtc0, and takes exc_req / epc_out to redirect the PC.

Parameters:
IRQ_NUM, 5, external interrupt lines (1..6)
NEST_DEPTH, 4, Status/EPC stack entries (2..8)
TIMER_DIV, 1, Count increments once every TIMER_DIV clocks (1..256)
EXC_VECTOR, 32'h0000_0004, handler entry address

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mtc0  in  1  write cp0_in to register addr
eret  in  1  exception return
addr  in  5  CP0 register index
cp0_in  in  32  mtc0 write data
pc  in  32  PC of the current instruction
exc_code_in  in  5  decoded sync exception: SYSCALL=8, BREAK=9, TEQ=13, otherwise none
teq_exc  in  1  TEQ operands equal
irq  in  IRQ_NUM  external interrupt requests, level-sensitive, already synchronous to clk
cp0_out  out  32  combinational read of register addr
epc_out  out  32  PC redirect target
exc_req  out  1  exception or interrupt taken this cycle (combinational)
nest_level  out  4  current stack occupancy
nest_ovf  out  1  sticky: exception taken while the stack was full

Behaviour:
Register map:
- Reg 9 Count: read/write.
- Reg 11 Compare: read/write.
- Reg 12 Status, bit fields:
  - bit0 IE;
  - bit1 SYSCALL mask; bit2 BREAK mask; bit3 TEQ mask;
  - bit8 timer mask;
  - bits[8+IRQ_NUM:9] irq masks;
  - all other bits read 0.
- Reg 13 Cause, bit fields:
  - [6:2] ExcCode;
  - bit8 TP (timer pending);
  - bits[8+IRQ_NUM:9] live irq levels.
  - Read-only; mtc0 to reg 13 is ignored.
- Reg 14 EPC: top-of-stack EPC.
- Other regs: plain 32-bit storage.

Reset (rst_n low, asynchronous):
- All registers, both stacks, prescaler, nest_level and nest_ovf go to 0.
- Outputs: cp0_out=0 (for any addr), exc_req=0, epc_out=EXC_VECTOR.
- rst_n asserted mid-exception aborts everything; no partial stack state survives.

Exception recognition (combinational, same cycle):
- sync = IE & ((mask1 & code==8) | (mask2 & code==9) | (mask3 & code==13 & teq_exc)).
- intr = IE & ~sync & |({irq,TP} & {irq masks, timer mask}).
- exc_req = sync | intr.
- epc_out = eret ? EPC top : EXC_VECTOR.

Priority per cycle: exception > eret > mtc0.
- An interrupt in an mtc0 cycle suppresses that write; the instruction is re-executed after return.

On exc_req (clock edge):
- If nest_level < NEST_DEPTH:
  - push current Status and pc onto the stacks;
  - nest_level += 1.
- If the stack is full:
  - overwrite the top entry;
  - set nest_ovf;
  - nest_level unchanged.
- Status.IE <= 0; masks are unchanged.
- Cause.ExcCode <= the sync code, or 0 for an interrupt.
- When several interrupts are pending, only ExcCode=0 is recorded; software reads the IP bits.

On eret (no exception that cycle):
- If nest_level > 0:
  - Status <= popped Status;
  - EPC top <= next entry (0 if the stack empties);
  - nest_level -= 1.
- If nest_level == 0: Status.IE <= 1 and nothing else changes.

mtc0 special cases:
- Reg 14: overwrites the top EPC entry, or the level-0 EPC register when the stack is empty.
- Reg 12: writes Status; unused bits are dropped.
- Reg 11: writes Compare and clears TP.
- Reg 9: writes Count and restarts the prescaler; it never sets TP.

Timer:
- The prescaler counts 0..TIMER_DIV-1; on the wrap, Count += 1, wrapping 32'hFFFFFFFF to 0.
- TP sets on the edge where the incremented Count equals Compare.
- TP stays set until Compare is written.
- TP set and Compare write in the same cycle: the write wins (TP=0).

nest_ovf clears only on reset.

Test Plan:
1. Reset, then Status=32'h0000_000F, then code=8, pc=32'h40 → exc_req=1; next cycle EPC=32'h40, Cause=32'h20, IE=0, nest_level=1. Then eret → epc_out=32'h40, Status back to 32'hF, nest_level=0.
2. Status=32'h0000_0201, irq[0]=1 during an mtc0 to reg 20 at pc=32'h80 → exc_req=1, reg 20 unchanged, EPC=32'h80, ExcCode=0, Cause bit9=1.
3. Nesting with NEST_DEPTH=2: three exceptions at pcs 0x10, 0x20, 0x30 with the handler re-enabling IE → nest_ovf=1, level=2, EPC=0x30. Then eret returns 0x30, and the next eret returns 0x10.
4. TIMER_DIV=1, Compare=5, Count written 0, timer mask+IE set → TP and exc_req assert exactly 5 clocks after the write. mtc0 Compare=100 clears TP.
5. Code=13 with teq_exc=0 → no exception. Code=9 with mask2=0 → no exception. mtc0 to reg 13 leaves Cause unchanged.
6. rst_n low mid-handler (level=3) → nest_level=0, nest_ovf=0, epc_out=32'h4 asynchronously, before the next clock.

Source files
------------

// File: rtl/cp0_nested_irq.sv
// MIPS coprocessor 0: interrupt lines, Count/Compare timer and a
// Status/EPC stack so that nested exceptions return to the right place.
module cp0_nested_irq #(
  parameter int          IRQ_NUM    = 5,
  parameter int          NEST_DEPTH = 4,
  parameter int          TIMER_DIV  = 1,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mtc0,
  input  logic               eret,
  input  logic [4:0]         addr,
  input  logic [31:0]        cp0_in,
  input  logic [31:0]        pc,
  input  logic [4:0]         exc_code_in,
  input  logic               teq_exc,
  input  logic [IRQ_NUM-1:0] irq,
  output logic [31:0]        cp0_out,
  output logic [31:0]        epc_out,
  output logic               exc_req,
  output logic [3:0]         nest_level,
  output logic               nest_ovf
);

  localparam int IW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam logic [31:0] ST_MASK =
    {{(23-IRQ_NUM){1'b0}}, {IRQ_NUM{1'b1}}, 9'h10F};

  logic [31:0] r_regs [32];
  logic [31:0] r_st_stk [NEST_DEPTH];
  logic [31:0] r_epc_stk [NEST_DEPTH];
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_status;
  logic [31:0] r_epc0;
  logic [4:0]  r_exccode;
  logic [3:0]  r_level;
  logic [7:0]  r_pre;
  logic        r_tp;
  logic        r_ovf;

  logic          w_ie;
  logic          w_sync;
  logic          w_intr;
  logic          w_exc;
  logic          w_eret;
  logic          w_wr;
  logic          w_empty;
  logic          w_full;
  logic          w_tick;
  logic [IW-1:0] w_top_idx;
  logic [IW-1:0] w_push_idx;
  logic [31:0]   w_epc_top;
  logic [31:0]   w_cause;
  logic [31:0]   w_cnt_inc;
  logic [31:0]   w_rd;
  logic [IRQ_NUM:0] w_pend;

  assign w_ie   = r_status[0];
  assign w_sync = w_ie & (
      (r_status[1] & (exc_code_in == 5'd8)) |
      (r_status[2] & (exc_code_in == 5'd9)) |
      (r_status[3] & (exc_code_in == 5'd13) & teq_exc));
  assign w_pend = {irq, r_tp} & r_status[8+IRQ_NUM:8];
  assign w_intr = w_ie & ~w_sync & (|w_pend);
  assign w_exc  = w_sync | w_intr;
  assign w_eret = eret & ~w_exc;
  assign w_wr   = mtc0 & ~w_exc & ~eret;

  assign w_empty    = (r_level == 4'd0);
  assign w_full     = (r_level == 4'(NEST_DEPTH));
  assign w_top_idx  = IW'(r_level - 4'd1);
  assign w_push_idx = w_full ? IW'(NEST_DEPTH - 1) : IW'(r_level);
  assign w_epc_top  = w_empty ? r_epc0 : r_epc_stk[w_top_idx];

  assign w_cause = {{(23-IRQ_NUM){1'b0}}, irq, r_tp,
                    1'b0, r_exccode, 2'b00};

  assign w_tick    = (r_pre == 8'(TIMER_DIV - 1));
  assign w_cnt_inc = r_count + 32'd1;

  always_comb begin
    w_rd = r_regs[addr];
    case (addr)
      5'd9:    w_rd = r_count;
      5'd11:   w_rd = r_compare;
      5'd12:   w_rd = r_status;
      5'd13:   w_rd = w_cause;
      5'd14:   w_rd = w_epc_top;
      default: w_rd = r_regs[addr];
    endcase
  end

  // Outputs are forced to their idle values while reset is held.
  assign cp0_out    = rst_n ? w_rd : 32'd0;
  assign epc_out    = (rst_n & eret) ? w_epc_top : EXC_VECTOR;
  assign exc_req    = w_exc;
  assign nest_level = r_level;
  assign nest_ovf   = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_compare <= '0;
      r_pre     <= '0;
      r_tp      <= 1'b0;
    end else begin
      if (w_wr && addr == 5'd9) begin
        r_count <= cp0_in;
        r_pre   <= '0;
      end else if (w_tick) begin
        r_count <= w_cnt_inc;
        r_pre   <= '0;
      end else begin
        r_pre <= r_pre + 8'd1;
      end
      if (w_wr && addr == 5'd11) begin
        r_compare <= cp0_in;
        r_tp      <= 1'b0;
      end else if (w_tick && !(w_wr && addr == 5'd9)
                   && w_cnt_inc == r_compare) begin
        r_tp <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        r_st_stk[i]  <= '0;
        r_epc_stk[i] <= '0;
      end
      r_status  <= '0;
      r_epc0    <= '0;
      r_exccode <= '0;
      r_level   <= '0;
      r_ovf     <= 1'b0;
    end else if (w_exc) begin
      r_st_stk[w_push_idx]  <= r_status;
      r_epc_stk[w_push_idx] <= pc;
      if (w_full) r_ovf   <= 1'b1;
      else        r_level <= r_level + 4'd1;
      r_status[0] <= 1'b0;
      r_exccode   <= w_sync ? exc_code_in : 5'd0;
    end else if (w_eret) begin
      if (!w_empty) begin
        r_status <= r_st_stk[w_top_idx];
        r_level  <= r_level - 4'd1;
        if (r_level == 4'd1) r_epc0 <= '0;
      end else begin
        r_status[0] <= 1'b1;
      end
    end else if (w_wr) begin
      case (addr)
        5'd9, 5'd11, 5'd13: ;
        5'd12: r_status <= cp0_in & ST_MASK;
        5'd14: begin
          if (w_empty) r_epc0 <= cp0_in;
          else         r_epc_stk[w_top_idx] <= cp0_in;
        end
        default: r_regs[addr] <= cp0_in;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_nested_irq.sv
// Directed bench: default-parameter instance plus a 2-deep instance
// driven by the same stimulus.
module tb_cp0_nested_irq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mtc0 = 1'b0;
  logic        eret = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] cp0_in = '0;
  logic [31:0] pc = '0;
  logic [4:0]  code = '0;
  logic        teq = 1'b0;
  logic [4:0]  irq = '0;

  logic [31:0] c4, e4, c2, e2;
  logic        x4, x2, ov4, ov2;
  logic [3:0]  lv4, lv2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cp0_nested_irq u_dut (
    .clk(clk), .rst_n(rst_n), .mtc0(mtc0), .eret(eret), .addr(addr),
    .cp0_in(cp0_in), .pc(pc), .exc_code_in(code), .teq_exc(teq),
    .irq(irq), .cp0_out(c4), .epc_out(e4), .exc_req(x4),
    .nest_level(lv4), .nest_ovf(ov4)
  );

  cp0_nested_irq #(.NEST_DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .mtc0(mtc0), .eret(eret), .addr(addr),
    .cp0_in(cp0_in), .pc(pc), .exc_code_in(code), .teq_exc(teq),
    .irq(irq), .cp0_out(c2), .epc_out(e2), .exc_req(x2),
    .nest_level(lv2), .nest_ovf(ov2)
  );

  typedef struct {
    logic [31:0] st;
    logic [4:0]  code;
    logic        teq;
    logic [4:0]  irq;
    logic        exc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    mtc0 = 1'b1; addr = a; cp0_in = d;
    @(posedge clk); #1;
    mtc0 = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    addr = a; #1;
  endtask

  task automatic take(input logic [31:0] p, input logic [4:0] c);
    @(negedge clk);
    pc = p; code = c; #1;
    chk("take_exc_req", 32'(x4), 32'd1);
    @(posedge clk); #1;
    code = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{32'h0000_000F, 5'd8,  1'b0, 5'h00, 1'b1};
    vecs[1]  = '{32'h0000_000E, 5'd8,  1'b0, 5'h00, 1'b0};
    vecs[2]  = '{32'h0000_000D, 5'd8,  1'b0, 5'h00, 1'b0};
    vecs[3]  = '{32'h0000_000F, 5'd9,  1'b0, 5'h00, 1'b1};
    vecs[4]  = '{32'h0000_000B, 5'd9,  1'b0, 5'h00, 1'b0};
    vecs[5]  = '{32'h0000_000F, 5'd13, 1'b1, 5'h00, 1'b1};
    vecs[6]  = '{32'h0000_000F, 5'd13, 1'b0, 5'h00, 1'b0};
    vecs[7]  = '{32'h0000_000F, 5'd5,  1'b0, 5'h00, 1'b0};
    vecs[8]  = '{32'h0000_0201, 5'd0,  1'b0, 5'h01, 1'b1};
    vecs[9]  = '{32'h0000_0201, 5'd0,  1'b0, 5'h02, 1'b0};
    vecs[10] = '{32'h0000_3E01, 5'd0,  1'b0, 5'h10, 1'b1};
    vecs[11] = '{32'h0000_0200, 5'd0,  1'b0, 5'h01, 1'b0};

    #2 rst_n = 1'b0;
    irq = 5'h1F; addr = 5'd13; eret = 1'b1; #1;
    chk("rst_cause_out", c4, 32'd0);
    chk("rst_epc_out", e4, 32'h4);
    chk("rst_exc_req", 32'(x4), 32'd0);
    irq = '0; eret = 1'b0; addr = 5'd12; #1;
    chk("rst_status", c4, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    wr(12, 32'hFFFF_FFFF);
    rd(12);
    chk("status_mask", c4, 32'h0000_3F0F);

    for (int i = 0; i < 12; i++) begin
      wr(12, vecs[i].st);
      @(negedge clk);
      code = vecs[i].code; teq = vecs[i].teq; irq = vecs[i].irq; #1;
      chk($sformatf("vec%0d_exc_req", i), 32'(x4), 32'(vecs[i].exc));
      code = '0; teq = 1'b0; irq = '0;
    end

    // Syscall, then return
    do_reset();
    wr(12, 32'h0000_000F);
    @(negedge clk);
    pc = 32'h40; code = 5'd8; #1;
    chk("sc_exc_req", 32'(x4), 32'd1);
    chk("sc_epc_vec", e4, 32'h4);
    @(posedge clk); #1;
    code = '0;
    rd(14); chk("sc_epc", c4, 32'h40);
    rd(13); chk("sc_cause", c4, 32'h20);
    rd(12); chk("sc_status", c4, 32'h0000_000E);
    chk("sc_level", 32'(lv4), 32'd1);
    @(negedge clk);
    eret = 1'b1; #1;
    chk("sc_eret_epc", e4, 32'h40);
    @(posedge clk); #1;
    eret = 1'b0;
    rd(12); chk("sc_status_back", c4, 32'h0000_000F);
    chk("sc_level0", 32'(lv4), 32'd0);
    rd(14); chk("sc_epc_empty", c4, 32'd0);
    wr(13, 32'hFFFF_FFFF);
    rd(13); chk("cause_ro", c4, 32'h20);

    // Interrupt suppresses an mtc0
    wr(20, 32'h55);
    wr(12, 32'h0000_0201);
    @(negedge clk);
    mtc0 = 1'b1; addr = 5'd20; cp0_in = 32'hDEAD; pc = 32'h80; irq = 5'h01;
    #1 chk("irq_exc_req", 32'(x4), 32'd1);
    @(posedge clk); #1;
    mtc0 = 1'b0;
    rd(20); chk("irq_reg20", c4, 32'h55);
    rd(14); chk("irq_epc", c4, 32'h80);
    rd(13); chk("irq_cause", c4, 32'h200);
    irq = '0;

    // Nesting and overflow
    do_reset();
    wr(12, 32'h0000_000F);
    take(32'h10, 5'd8);
    wr(12, 32'h0000_000F);
    take(32'h20, 5'd8);
    chk("nest_lv2", 32'(lv2), 32'd2);
    chk("nest_ovf_early", 32'(ov2), 32'd0);
    wr(12, 32'h0000_000F);
    take(32'h30, 5'd8);
    chk("nest_ovf", 32'(ov2), 32'd1);
    chk("nest_lv2_full", 32'(lv2), 32'd2);
    chk("nest_lv4", 32'(lv4), 32'd3);
    chk("nest_ovf4", 32'(ov4), 32'd0);
    rd(14); chk("nest_epc_top", c2, 32'h30);
    @(negedge clk);
    eret = 1'b1; #1;
    chk("nest_eret1", e2, 32'h30);
    @(posedge clk); #1;
    chk("nest_eret2", e2, 32'h10);
    chk("nest_eret2_d4", e4, 32'h20);
    @(posedge clk); #1;
    eret = 1'b0;
    chk("nest_lv2_end", 32'(lv2), 32'd0);

    // Timer
    do_reset();
    wr(12, 32'h0000_0101);
    wr(11, 32'd5);
    wr(9, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("tmr_k%0d", k), 32'(x4), (k == 5) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    rd(13); chk("tmr_tp_held", c4, 32'h100);
    wr(11, 32'd100);
    rd(13); chk("tmr_tp_clr", c4, 32'd0);
    rd(11); chk("tmr_compare", c4, 32'd100);

    // Reset while three levels deep
    do_reset();
    wr(12, 32'h0000_000F);
    take(32'h10, 5'd9);
    wr(12, 32'h0000_000F);
    take(32'h20, 5'd9);
    wr(12, 32'h0000_000F);
    take(32'h30, 5'd9);
    eret = 1'b1; #1;
    chk("rst_mid_pre_epc", e4, 32'h30);
    rst_n = 1'b0; #1;
    chk("rst_mid_level", 32'(lv4), 32'd0);
    chk("rst_mid_ovf2", 32'(ov2), 32'd0);
    chk("rst_mid_epc", e4, 32'h4);
    eret = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rd(14); chk("rst_mid_epc_reg", c4, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
